// File: rtl/alu_pkg.sv
// alu_pkg: shared widths and the packed ALU result entry
package alu_pkg;
    localparam int ALU_W  = 8;
    localparam int FLAG_W = 5;
    typedef struct packed {
        logic [ALU_W-1:0] y;
        logic             parity;
        logic             overflow;
        logic             greater;
        logic             is_eq;
        logic             less;
    } alu_result_t;
endpackage

// File: rtl/alu_result_queue_if.sv
// alu_result_queue_if: upstream/downstream handshake and status bundle of the result queue
interface alu_result_queue_if #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
);
    logic                       in_valid;
    logic                       in_ready;
    logic [alu_pkg::ALU_W-1:0]  in_y;
    logic                       in_parity;
    logic                       in_overflow;
    logic                       in_greater;
    logic                       in_is_eq;
    logic                       in_less;
    logic                       out_valid;
    logic                       out_ready;
    logic [alu_pkg::ALU_W-1:0]  out_y;
    logic                       out_parity;
    logic                       out_overflow;
    logic                       out_greater;
    logic                       out_is_eq;
    logic                       out_less;
    logic [$clog2(DEPTH):0]     level;
    logic [CNT_W-1:0]           drop_cnt;
    logic [CNT_W-1:0]           eq_cnt;
    logic                       ovf_sticky;
    modport master (
        output in_valid, in_y, in_parity, in_overflow, in_greater, in_is_eq, in_less, out_ready,
        input  in_ready, out_valid, out_y, out_parity, out_overflow, out_greater, out_is_eq, out_less,
        input  level, drop_cnt, eq_cnt, ovf_sticky
    );
    modport slave (
        input  in_valid, in_y, in_parity, in_overflow, in_greater, in_is_eq, in_less, out_ready,
        output in_ready, out_valid, out_y, out_parity, out_overflow, out_greater, out_is_eq, out_less,
        output level, drop_cnt, eq_cnt, ovf_sticky
    );
endinterface

// File: rtl/alu_result_queue_fifo.sv
// alu_res_fifo: result storage with wrap-bit read/write pointers
module alu_res_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  alu_result_t            din,
    output alu_result_t            dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    alu_result_t r_mem [DEPTH];
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    // pointers advance on push/pop; flush and reset return both to zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (push) r_wptr <= r_wptr + 1'b1;
            if (pop)  r_rptr <= r_rptr + 1'b1;
        end
    end
    // storage needs no reset since pointers alone define valid contents
    always_ff @(posedge clk) begin
        if (push) r_mem[r_wptr[AW-1:0]] <= din;
    end
    assign dout  = r_mem[r_rptr[AW-1:0]];
    assign empty = (r_wptr == r_rptr);
    assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign level = r_wptr - r_rptr;
endmodule

// File: rtl/alu_result_queue.sv
// alu_result_queue: FIFO of ALU results with drop/equality counters and sticky overflow
module alu_result_queue
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    alu_result_queue_if.slave   bus
);
    alu_result_t w_din;
    alu_result_t w_dout;
    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic        w_drop;
    logic [CNT_W-1:0] r_drop_cnt;
    logic [CNT_W-1:0] r_eq_cnt;
    logic             r_ovf_sticky;
    assign w_din  = {bus.in_y, bus.in_parity, bus.in_overflow, bus.in_greater, bus.in_is_eq, bus.in_less};
    assign bus.in_ready = !w_full && !clr;
    assign w_push = bus.in_valid && bus.in_ready;
    assign w_pop  = !w_empty && bus.out_ready && !clr;
    assign w_drop = bus.in_valid && !bus.in_ready;
    alu_res_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .flush (clr),
        .din   (w_din),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty),
        .level (bus.level)
    );
    assign bus.out_valid    = !w_empty;
    assign bus.out_y        = w_dout.y;
    assign bus.out_parity   = w_dout.parity;
    assign bus.out_overflow = w_dout.overflow;
    assign bus.out_greater  = w_dout.greater;
    assign bus.out_is_eq    = w_dout.is_eq;
    assign bus.out_less     = w_dout.less;
    assign bus.drop_cnt     = r_drop_cnt;
    assign bus.eq_cnt       = r_eq_cnt;
    assign bus.ovf_sticky   = r_ovf_sticky;
    // statistics: saturating drop count, wrapping equality count, sticky overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_cnt   <= '0;
            r_eq_cnt     <= '0;
            r_ovf_sticky <= 1'b0;
        end else if (clr) begin
            r_drop_cnt   <= CNT_W'(w_drop);
            r_eq_cnt     <= '0;
            r_ovf_sticky <= 1'b0;
        end else begin
            if (w_drop && r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
            if (w_push && bus.in_is_eq)     r_eq_cnt   <= r_eq_cnt + 1'b1;
            if (w_push && bus.in_overflow)  r_ovf_sticky <= 1'b1;
        end
    end
endmodule
